// File: rtl/zybo_top.sv
// Zybo board I/O: UART RX/TX on PMOD E, 2-digit hex display, LEDs, debounced buttons/switches.
// Optional macro HEARTBEAT_EN: leds_o[3] becomes a ~1.49 Hz heartbeat from a free-running counter.
module zybo_top #(
    parameter int CLK_HZ        = 50000000,
    parameter int BAUD          = 115200,
    parameter int REFRESH_BITS  = 16,
    parameter int DEBOUNCE_BITS = 20
) (
    input  logic       clk_50MHz_i,
    input  logic       reset_async,
    input  logic [1:0] buttons_i,
    input  logic [1:0] switches_i,
    input  logic       pmod_e_3_rxd_i,
    output logic       pmod_e_2_txd_o,
    output logic [3:0] leds_o,
    output logic [7:0] SEG_o,
    output logic [1:0] COM_o
);
    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = $clog2(BIT_CYC);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // ---------------- input synchronisers ----------------
    logic [1:0] rxd_sync;
    logic [1:0] btn_meta, btn_s;
    logic [1:0] sw_meta, sw_s;
    logic       rxd;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50MHz_i or negedge reset_async) begin
        if (!reset_async) begin
            rxd_sync <= 2'b11;
            btn_meta <= '0;
            btn_s    <= '0;
            sw_meta  <= '0;
            sw_s     <= '0;
        end else begin
            rxd_sync <= {rxd_sync[0], pmod_e_3_rxd_i};
            btn_meta <= buttons_i;
            btn_s    <= btn_meta;
            sw_meta  <= switches_i;
            sw_s     <= sw_meta;
        end
    end

    assign rxd = rxd_sync[1];

    // ---------------- UART receiver ----------------
    rx_state_t     rx_state, rx_state_nx;
    logic [CW-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]    rx_bit, rx_bit_nx;
    logic [7:0]    rx_shift, rx_shift_nx;
    logic          rx_prev, rx_done, rx_valid;
    logic [7:0]    rx_byte;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt + CW'(1);
        rx_bit_nx   = rx_bit;
        rx_shift_nx = rx_shift;
        rx_done     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nx = '0;
                if (rx_prev && !rxd) rx_state_nx = RX_START;
            end
            RX_START: begin
                if (rx_cnt == CW'(HALF_CYC - 1)) begin
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = '0;
                    rx_state_nx = rxd ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CW'(BIT_CYC - 1)) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rxd, rx_shift[7:1]};
                    rx_bit_nx   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
                end
            end
            default: begin
                if (rx_cnt == CW'(BIT_CYC - 1)) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = RX_IDLE;
                    rx_done     = rxd;
                end
            end
        endcase
    end

    always_ff @(posedge clk_50MHz_i or negedge reset_async) begin
        if (!reset_async) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_prev  <= 1'b1;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_shift <= rx_shift_nx;
            rx_prev  <= rxd;
            rx_valid <= rx_done;
            if (rx_done) rx_byte <= rx_shift;
        end
    end

    // ---------------- button debounce ----------------
    logic [DEBOUNCE_BITS-1:0] db_cnt;
    logic [1:0]               btn_db, btn_fire;
    logic                     db_tick;

    assign db_tick  = &db_cnt;
    assign btn_fire = db_tick ? (btn_s & ~btn_db) : 2'b00;

    always_ff @(posedge clk_50MHz_i or negedge reset_async) begin
        if (!reset_async) begin
            db_cnt <= '0;
            btn_db <= '0;
        end else begin
            db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
            if (db_tick) btn_db <= btn_s;
        end
    end

    // ---------------- UART transmitter ----------------
    tx_state_t     tx_state, tx_state_nx;
    logic [CW-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0]    tx_bit, tx_bit_nx;
    logic [7:0]    tx_shift, tx_shift_nx, tx_data;
    logic          tx_req, txd_nx, echo;

    // Echo wins over a same-cycle status request.
    assign echo    = rx_valid & sw_s[1];
    assign tx_req  = echo | btn_fire[0];
    assign tx_data = echo ? rx_byte : {2'b10, sw_s, leds_o};

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt + CW'(1);
        tx_bit_nx   = tx_bit;
        tx_shift_nx = tx_shift;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nx = '0;
                if (tx_req) begin
                    tx_state_nx = TX_START;
                    tx_shift_nx = tx_data;
                    tx_bit_nx   = '0;
                end
            end
            TX_START: begin
                if (tx_cnt == CW'(BIT_CYC - 1)) begin
                    tx_cnt_nx   = '0;
                    tx_state_nx = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == CW'(BIT_CYC - 1)) begin
                    tx_cnt_nx   = '0;
                    tx_shift_nx = {1'b0, tx_shift[7:1]};
                    tx_bit_nx   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_nx = TX_STOP;
                end
            end
            default: begin
                if (tx_cnt == CW'(BIT_CYC - 1)) begin
                    tx_cnt_nx   = '0;
                    tx_state_nx = TX_IDLE;
                end
            end
        endcase
        // Line level is derived from the next state so the output is a clean register.
        case (tx_state_nx)
            TX_START: txd_nx = 1'b0;
            TX_DATA:  txd_nx = tx_shift_nx[0];
            default:  txd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk_50MHz_i or negedge reset_async) begin
        if (!reset_async) begin
            tx_state       <= TX_IDLE;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_shift       <= '0;
            pmod_e_2_txd_o <= 1'b1;
        end else begin
            tx_state       <= tx_state_nx;
            tx_cnt         <= tx_cnt_nx;
            tx_bit         <= tx_bit_nx;
            tx_shift       <= tx_shift_nx;
            pmod_e_2_txd_o <= txd_nx;
        end
    end

    // ---------------- display register and LEDs ----------------
    logic [7:0] disp;
`ifdef HEARTBEAT_EN
    logic [24:0] hb_cnt;
`endif

    always_ff @(posedge clk_50MHz_i or negedge reset_async) begin
        if (!reset_async) begin
            disp   <= '0;
            leds_o <= '0;
`ifdef HEARTBEAT_EN
            hb_cnt <= '0;
`endif
        end else begin
            if (rx_valid)    disp <= rx_byte;
            if (btn_fire[1]) disp <= '0;
`ifdef HEARTBEAT_EN
            hb_cnt    <= hb_cnt + 25'd1;
            leds_o[3] <= hb_cnt[24];
            if (rx_valid)    leds_o[2:0] <= rx_byte[2:0];
            if (btn_fire[1]) leds_o[2:0] <= '0;
`else
            if (rx_valid)    leds_o <= rx_byte[3:0];
            if (btn_fire[1]) leds_o <= '0;
`endif
        end
    end

    // ---------------- multiplexed 7-segment ----------------
    logic [REFRESH_BITS-1:0] ref_cnt;
    logic                    digit;

    always_ff @(posedge clk_50MHz_i or negedge reset_async) begin
        if (!reset_async) begin
            ref_cnt <= '0;
            digit   <= 1'b0;
            SEG_o   <= 8'hFF;
            COM_o   <= 2'b11;
        end else begin
            ref_cnt <= ref_cnt + REFRESH_BITS'(1);
            if (&ref_cnt) digit <= ~digit;
            if (sw_s[0]) begin
                COM_o <= 2'b11;
                SEG_o <= 8'hFF;
            end else if (!digit) begin
                COM_o <= 2'b10;
                SEG_o <= hex7(disp[3:0]);
            end else begin
                COM_o <= 2'b01;
                SEG_o <= hex7(disp[7:4]);
            end
        end
    end

endmodule

// File: tb/tb_zybo_top.sv
// Directed bench for zybo_top: reset, RX display/LED update, echo, framing error, buttons, blanking.
module tb_zybo_top;
    localparam int BIT = 434;
    localparam int DB  = 64;   // debounce period with DEBOUNCE_BITS=6

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] buttons, switches;
    logic       rxd, txd;
    logic [3:0] leds;
    logic [7:0] seg;
    logic [1:0] com;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_bytes[$];
    int         tx_low[$];
    logic       tx_stop[$];
    int         tx_starts = 0;

    always #10 clk = ~clk;

    zybo_top #(
        .CLK_HZ(50000000), .BAUD(115200), .REFRESH_BITS(4), .DEBOUNCE_BITS(6)
    ) dut (
        .clk_50MHz_i(clk), .reset_async(rst_n), .buttons_i(buttons), .switches_i(switches),
        .pmod_e_3_rxd_i(rxd), .pmod_e_2_txd_o(txd), .leds_o(leds), .SEG_o(seg), .COM_o(com)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receives every frame on txd: bytes, stop bit and length of the initial low run.
    initial begin
        logic [7:0] b;
        int         rise;
        logic       stopb;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                tx_starts++;
                b = '0; rise = -1; stopb = 1'b0;
                for (int n = 0; n < 10 * BIT; n++) begin
                    if (n > 0) @(negedge clk);
                    if (rise < 0 && txd === 1'b1) rise = n;
                    for (int k = 1; k <= 9; k++)
                        if (n == BIT / 2 + k * BIT) begin
                            if (k == 9) stopb = txd;
                            else b[k-1] = txd;
                        end
                end
                tx_bytes.push_back(b);
                tx_low.push_back(rise);
                tx_stop.push_back(stopb);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic uart_send(input logic [7:0] d, input logic stop_bit);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic check_digit(input string tag, input logic [1:0] want, input logic [7:0] exp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (com !== want && n < 64);
        if (com !== want) check({tag, "_com"}, com, want);
        else check(tag, seg, exp);
    endtask

    task automatic wait_tx(input string tag, input int want, input logic [7:0] exp_b, input int exp_low);
        int n;
        n = 0;
        while (tx_bytes.size() < want && n < 12 * BIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_count"}, tx_bytes.size(), want);
        if (tx_bytes.size() >= want) begin
            check({tag, "_byte"}, tx_bytes[want-1], exp_b);
            check({tag, "_stop"}, tx_stop[want-1], 1'b1);
            check({tag, "_low_run"}, tx_low[want-1], exp_low);
        end
    endtask

    initial begin
        int s0;
        rst_n = 1'b0; buttons = '0; switches = '0; rxd = 1'b1;
        repeat (500) @(negedge clk);
        check("rst_leds", leds, 4'h0);
        check("rst_txd", txd, 1'b1);
        check("rst_seg", seg, 8'hFF);
        check("rst_com", com, 2'b11);
        rst_n = 1'b1;
        check_digit("post_rst_d0", 2'b10, 8'hC0);
        check_digit("post_rst_d1", 2'b01, 8'hC0);

        // Receive 0x3C with echo enabled
        switches = 2'b10;
        repeat (5) @(negedge clk);
        uart_send(8'h3C, 1'b1);
        check("echo_leds", leds, 4'hC);
        check_digit("echo_d0", 2'b10, 8'hC6);
        check_digit("echo_d1", 2'b01, 8'hB0);
        wait_tx("echo_tx", 1, 8'h3C, 3 * BIT);

        // Receive 0xA7 with echo disabled
        switches = 2'b00;
        repeat (5) @(negedge clk);
        s0 = tx_starts;
        uart_send(8'hA7, 1'b1);
        check("noecho_leds", leds, 4'h7);
        check_digit("noecho_d0", 2'b10, 8'hF8);
        check_digit("noecho_d1", 2'b01, 8'h88);
        check("noecho_tx_starts", tx_starts, s0);
        check("noecho_txd", txd, 1'b1);

        // Button 1 clears display and LEDs
        buttons = 2'b10;
        repeat (3 * DB) @(negedge clk);
        buttons = 2'b00;
        repeat (DB) @(negedge clk);
        check("clr_leds", leds, 4'h0);
        check_digit("clr_d0", 2'b10, 8'hC0);
        check_digit("clr_d1", 2'b01, 8'hC0);

        // Framing error with echo enabled: no side effects
        switches = 2'b10;
        repeat (5) @(negedge clk);
        s0 = tx_starts;
        uart_send(8'h3C, 1'b0);
        check("ferr_leds", leds, 4'h0);
        check_digit("ferr_d0", 2'b10, 8'hC0);
        check_digit("ferr_d1", 2'b01, 8'hC0);
        check("ferr_tx_starts", tx_starts, s0);

        // Status byte request via button 0 while display blanked
        switches = 2'b00;
        repeat (5) @(negedge clk);
        uart_send(8'h05, 1'b1);
        check("stat_leds", leds, 4'h5);
        switches = 2'b01;
        repeat (6) @(negedge clk);
        check("blank_com_a", com, 2'b11);
        check("blank_seg_a", seg, 8'hFF);
        repeat (20) @(negedge clk);
        check("blank_com_b", com, 2'b11);
        check("blank_seg_b", seg, 8'hFF);
        s0 = tx_starts;
        buttons = 2'b01;
        repeat (3 * DB) @(negedge clk);
        buttons = 2'b00;
        wait_tx("stat_tx", 2, 8'h95, BIT);
        repeat (2 * BIT) @(negedge clk);
        check("stat_single_frame", tx_starts, s0 + 1);
        check("stat_txd_idle", txd, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
